// File: rtl/vga_timing_pkg.sv
// Shared types and default 1280x1024@60 timing constants for the VGA raster generator.
package vga_timing_pkg;

  typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} phase_t;

  localparam int CNT_W       = 11;
  localparam int FRAME_CNT_W = 16;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 48;
  localparam int DEF_H_SYNC   = 112;
  localparam int DEF_H_BP     = 248;
  localparam int DEF_V_ACTIVE = 1024;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 38;

  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: position counter, phase decode and sync level, all registered on the same edge.
module timing_axis
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE_LEN = DEF_H_ACTIVE,
  parameter int   FP_LEN     = DEF_H_FP,
  parameter int   SYNC_LEN   = DEF_H_SYNC,
  parameter int   BP_LEN     = DEF_H_BP,
  parameter logic SYNC_POL   = 1'b1
) (
  input  logic             VGA_CLK,
  input  logic             reset,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output phase_t           phase,
  output logic             sync,
  output logic             wrap
);

  localparam int               TOTAL      = total(ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN);
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FP_START   = CNT_W'(ACTIVE_LEN);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE_LEN + FP_LEN);
  localparam logic [CNT_W-1:0] BP_START   = CNT_W'(ACTIVE_LEN + FP_LEN + SYNC_LEN);

  logic [CNT_W-1:0] count_next;
  phase_t           phase_next;

  function automatic phase_t phase_of(input logic [CNT_W-1:0] c);
    if (c < FP_START)   return ACTIVE;
    if (c < SYNC_START) return FP;
    if (c < BP_START)   return SYNC;
    return BP;
  endfunction

  // Phase and sync are decoded from the next count so they land on the same edge as the count.
  always_comb begin
    wrap       = advance && (count == LAST);
    count_next = count;
    if (wrap)
      count_next = '0;
    else if (advance)
      count_next = count + 1'b1;
    phase_next = phase_of(count_next);
  end

  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      count <= LAST;
      phase <= BP;
      sync  <= ~SYNC_POL;
    end else begin
      count <= count_next;
      phase <= phase_next;
      sync  <= (phase_next == SYNC) ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 1280x1024@60 raster timing generator: pixel coordinates, display enable, frame pulses and delayed DAC sync/blank.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   PIX_LAT  = 1
) (
  input  logic                   VGA_CLK,
  input  logic                   reset,
  output logic [CNT_W-1:0]       x,
  output logic [CNT_W-1:0]       y,
  output logic                   disp_en,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_BLANK_N,
  output logic                   VGA_SYNC_N
);

  localparam logic [CNT_W-1:0] H_LAST_ACT = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_LAST_ACT = CNT_W'(V_ACTIVE - 1);

  phase_t h_phase, v_phase;
  logic   hs_raw, vs_raw;
  logic   h_wrap, v_wrap;
  logic   h_active_next, v_active_next;
  logic   counting;

  timing_axis #(
    .ACTIVE_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP), .SYNC_POL(HS_POL)
  ) u_h_axis (
    .VGA_CLK (VGA_CLK),
    .reset   (reset),
    .advance (1'b1),
    .count   (x),
    .phase   (h_phase),
    .sync    (hs_raw),
    .wrap    (h_wrap)
  );

  timing_axis #(
    .ACTIVE_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP), .SYNC_POL(VS_POL)
  ) u_v_axis (
    .VGA_CLK (VGA_CLK),
    .reset   (reset),
    .advance (h_wrap),
    .count   (y),
    .phase   (v_phase),
    .sync    (vs_raw),
    .wrap    (v_wrap)
  );

  // Active regions start at 0, so the next state is active after a wrap or while still inside the region.
  always_comb begin
    h_active_next = h_wrap || ((h_phase == ACTIVE) && (x != H_LAST_ACT));
    if (h_wrap)
      v_active_next = v_wrap || ((v_phase == ACTIVE) && (y != V_LAST_ACT));
    else
      v_active_next = (v_phase == ACTIVE);
  end

  // The wrap out of the reset state starts frame 0 and is deliberately not counted.
  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      disp_en     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      counting    <= 1'b0;
    end else begin
      disp_en     <= h_active_next && v_active_next;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      counting    <= 1'b1;
      if (v_wrap && counting)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign VGA_SYNC_N = 1'b0;

  generate
    if (PIX_LAT == 0) begin : g_no_lat
      assign VGA_HS      = hs_raw;
      assign VGA_VS      = vs_raw;
      assign VGA_BLANK_N = disp_en;
    end else begin : g_lat
      logic [PIX_LAT-1:0] hs_pipe, vs_pipe, bn_pipe;

      always_ff @(posedge VGA_CLK or negedge reset) begin
        if (!reset) begin
          hs_pipe <= {PIX_LAT{~HS_POL}};
          vs_pipe <= {PIX_LAT{~VS_POL}};
          bn_pipe <= '0;
        end else begin
          hs_pipe <= PIX_LAT'({hs_pipe, hs_raw});
          vs_pipe <= PIX_LAT'({vs_pipe, vs_raw});
          bn_pipe <= PIX_LAT'({bn_pipe, disp_en});
        end
      end

      assign VGA_HS      = hs_pipe[PIX_LAT-1];
      assign VGA_VS      = vs_pipe[PIX_LAT-1];
      assign VGA_BLANK_N = bn_pipe[PIX_LAT-1];
    end
  endgenerate

endmodule
